// File: rtl/gal_receptionist.sv
// rtl/gal_receptionist.sv - GULF UDP ingress to Galapagos stream adapter with port filtering
module gal_receptionist #(
  parameter int          DATA_WIDTH  = 512,
  parameter int          DEST_WIDTH  = 8,
  parameter logic [15:0] PORT_BASE   = 16'd8000,
  parameter int          NUM_KERNELS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    gulf_tvalid,
  output logic                    gulf_tready,
  input  logic [DATA_WIDTH-1:0]   gulf_tdata,
  input  logic [DATA_WIDTH/8-1:0] gulf_tkeep,
  input  logic                    gulf_tlast,
  input  logic [31:0]             ip,
  input  logic [15:0]             src_prt,
  input  logic [15:0]             dst_prt,
  output logic                    gal_tvalid,
  input  logic                    gal_tready,
  output logic [DATA_WIDTH-1:0]   gal_tdata,
  output logic [DATA_WIDTH/8-1:0] gal_tkeep,
  output logic                    gal_tlast,
  output logic [47:0]             gal_tuser,
  output logic [DEST_WIDTH-1:0]   gal_tdest,
  output logic [31:0]             drop_count
);

  localparam int          KW = DATA_WIDTH / 8;
  localparam int          EW = DATA_WIDTH + KW + 1 + 48 + DEST_WIDTH;
  localparam logic [31:0] NK = 32'(NUM_KERNELS);

  localparam logic [1:0] ST_SOP  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  tready_q;
  logic                  main_valid_q, main_valid_d;
  logic                  skid_full_q, skid_full_d;
  logic [EW-1:0]         main_q, main_d;
  logic [EW-1:0]         skid_q, skid_d;
  logic [47:0]           meta_user_q, meta_user_d;
  logic [DEST_WIDTH-1:0] meta_dest_q, meta_dest_d;
  logic [31:0]           drop_q, drop_d;

  logic                  accept, consume, first, hit, push;
  logic [31:0]           port_off;
  logic [47:0]           in_user;
  logic [DEST_WIDTH-1:0] in_dest;
  logic [EW-1:0]         in_entry;

  // Classification of the incoming beat; the first beat carries fresh meta, later beats the latched copy
  always_comb begin
    accept   = gulf_tvalid && tready_q;
    consume  = main_valid_q && gal_tready;
    first    = (state_q == ST_SOP);
    port_off = {16'd0, dst_prt} - {16'd0, PORT_BASE};
    hit      = (dst_prt >= PORT_BASE) && (port_off < NK);
    push     = accept && ((first && hit) || (state_q == ST_PASS));
    in_user  = first ? {src_prt, ip} : meta_user_q;
    in_dest  = first ? port_off[DEST_WIDTH-1:0] : meta_dest_q;
    in_entry = {gulf_tdata, gulf_tkeep, gulf_tlast, in_user, in_dest};
  end

  // Packet state machine, metadata latch and saturating drop counter
  always_comb begin
    state_d     = state_q;
    meta_user_d = meta_user_q;
    meta_dest_d = meta_dest_q;
    drop_d      = drop_q;
    case (state_q)
      ST_SOP: begin
        if (accept) begin
          if (hit) begin
            meta_user_d = in_user;
            meta_dest_d = in_dest;
            state_d     = gulf_tlast ? ST_SOP : ST_PASS;
          end else begin
            if (drop_q != 32'hFFFF_FFFF) drop_d = drop_q + 32'd1;
            state_d = gulf_tlast ? ST_SOP : ST_DROP;
          end
        end
      end
      ST_PASS, ST_DROP: begin
        if (accept && gulf_tlast) state_d = ST_SOP;
      end
      default: state_d = ST_SOP;
    endcase
  end

  // Two-entry skid buffer: main drives the outputs, skid absorbs one beat while main is stalled
  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    skid_full_d  = skid_full_q;
    if (skid_full_q) begin
      if (consume) begin
        main_d      = skid_q;
        skid_full_d = 1'b0;
      end
    end else if (!main_valid_q || consume) begin
      if (push) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else if (consume) begin
        main_valid_d = 1'b0;
      end
    end else if (push) begin
      skid_d      = in_entry;
      skid_full_d = 1'b1;
    end
  end

  // State registers; ready is registered from the next skid occupancy so it never admits a third beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SOP;
      tready_q     <= 1'b0;
      main_valid_q <= 1'b0;
      skid_full_q  <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      meta_user_q  <= '0;
      meta_dest_q  <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      tready_q     <= !skid_full_d;
      main_valid_q <= main_valid_d;
      skid_full_q  <= skid_full_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      meta_user_q  <= meta_user_d;
      meta_dest_q  <= meta_dest_d;
      drop_q       <= drop_d;
    end
  end

  assign gulf_tready = tready_q;
  assign gal_tvalid  = main_valid_q;
  assign gal_tdest   = main_q[DEST_WIDTH-1:0];
  assign gal_tuser   = main_q[DEST_WIDTH +: 48];
  assign gal_tlast   = main_q[DEST_WIDTH + 48];
  assign gal_tkeep   = main_q[DEST_WIDTH + 49 +: KW];
  assign gal_tdata   = main_q[DEST_WIDTH + 49 + KW +: DATA_WIDTH];
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_gal_receptionist.sv
// tb/tb_gal_receptionist.sv - self-checking bench for gal_receptionist
module tb_gal_receptionist;

  logic        clk = 1'b0;
  logic        rst;
  logic        gulf_tvalid, gulf_tready;
  logic [63:0] gulf_tdata;
  logic [7:0]  gulf_tkeep;
  logic        gulf_tlast;
  logic [31:0] ip;
  logic [15:0] src_prt, dst_prt;
  logic        gal_tvalid, gal_tready;
  logic [63:0] gal_tdata;
  logic [7:0]  gal_tkeep;
  logic        gal_tlast;
  logic [47:0] gal_tuser;
  logic [7:0]  gal_tdest;
  logic [31:0] drop_count;

  gal_receptionist #(.DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .gulf_tvalid(gulf_tvalid), .gulf_tready(gulf_tready), .gulf_tdata(gulf_tdata),
    .gulf_tkeep(gulf_tkeep), .gulf_tlast(gulf_tlast),
    .ip(ip), .src_prt(src_prt), .dst_prt(dst_prt),
    .gal_tvalid(gal_tvalid), .gal_tready(gal_tready), .gal_tdata(gal_tdata),
    .gal_tkeep(gal_tkeep), .gal_tlast(gal_tlast), .gal_tuser(gal_tuser),
    .gal_tdest(gal_tdest), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d; logic [7:0] k; logic l;
    logic [31:0] ip; logic [15:0] sp; logic [15:0] dp;
  } beat_t;
  typedef struct {
    logic [63:0] d; logic [7:0] k; logic l; logic [47:0] u; logic [7:0] t;
  } out_t;

  beat_t in_q[$];
  out_t  exp_q[$];
  out_t  obs_q[$];
  int    obs_cyc[$];

  int          checks = 0, errors = 0, cyc = 0;
  int          vpct = 100, rmode = 0, bp_lo = 0, bp_hi = 0;
  bit          ready_ok = 0, saw_stall = 0;
  bit          in_pkt = 0, keep_pkt = 0;
  logic [47:0] cur_u;
  logic [7:0]  cur_t;
  int unsigned drops = 0;
  logic [63:0] sent[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic beat_t mk(bit l, logic [15:0] dp, logic [31:0] ipv, logic [15:0] sp);
    beat_t b;
    b.d = {$urandom, $urandom}; b.k = 8'($urandom); b.l = l;
    b.ip = ipv; b.sp = sp; b.dp = dp;
    return b;
  endfunction

  // first beat carries the given meta; later beats carry junk meta that must be ignored
  task automatic add_pkt(input int n, input logic [15:0] dp, input logic [31:0] ipv, input logic [15:0] sp);
    for (int i = 0; i < n; i++) begin
      if (i == 0) in_q.push_back(mk(n == 1, dp, ipv, sp));
      else        in_q.push_back(mk(i == n - 1, 16'($urandom), $urandom, 16'($urandom)));
    end
  endtask

  // packet-level reference: classify on the first beat, forward or count a drop
  task automatic model_accept(input beat_t b);
    int p;
    out_t o;
    if (!in_pkt) begin
      p        = int'(b.dp) - 8000;
      keep_pkt = (p >= 0) && (p < 16);
      cur_u    = {b.sp, b.ip};
      cur_t    = 8'(p);
      if (!keep_pkt && drops != 32'hFFFF_FFFF) drops++;
    end
    if (keep_pkt) begin
      o.d = b.d; o.k = b.k; o.l = b.l; o.u = cur_u; o.t = cur_t;
      exp_q.push_back(o);
    end
    in_pkt = !b.l;
  endtask

  task automatic step(input bit r);
    out_t e, o;
    @(negedge clk);
    cyc++;
    chk("gulf_tready", gulf_tready, ready_ok && exp_q.size() < 2);
    chk("gal_tvalid", gal_tvalid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      chk("gal_tdata", gal_tdata, e.d);
      chk("gal_tkeep", gal_tkeep, e.k);
      chk("gal_tlast", gal_tlast, e.l);
      chk("gal_tuser", gal_tuser, e.u);
      chk("gal_tdest", gal_tdest, e.t);
    end
    chk("drop_count", drop_count, drops);
    if (!gulf_tready && ready_ok) saw_stall = 1;

    rst = r;
    case (rmode)
      0:       gal_tready = 1'b1;
      1:       gal_tready = ($urandom_range(99) < 60);
      default: gal_tready = !(cyc >= bp_lo && cyc < bp_hi);
    endcase
    if (in_q.size() > 0 && $urandom_range(99) < vpct) begin
      gulf_tvalid = 1'b1;
      gulf_tdata = in_q[0].d; gulf_tkeep = in_q[0].k; gulf_tlast = in_q[0].l;
      ip = in_q[0].ip; src_prt = in_q[0].sp; dst_prt = in_q[0].dp;
    end else begin
      gulf_tvalid = 1'b0;
      gulf_tdata = {$urandom, $urandom}; gulf_tkeep = 8'($urandom); gulf_tlast = 1'($urandom);
      ip = $urandom; src_prt = 16'($urandom); dst_prt = 16'($urandom_range(7990, 8020));
    end

    if (r) begin
      exp_q.delete(); in_pkt = 0; drops = 0; ready_ok = 0;
    end else begin
      if (gal_tvalid && gal_tready) begin
        o.d = gal_tdata; o.k = gal_tkeep; o.l = gal_tlast; o.u = gal_tuser; o.t = gal_tdest;
        obs_q.push_back(o);
        obs_cyc.push_back(cyc);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (gulf_tvalid && gulf_tready) model_accept(in_q.pop_front());
      ready_ok = 1;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step(0);
      n++;
    end
    if (in_q.size() > 0 || exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d inputs and %0d outputs pending after %0d cycles", in_q.size(), exp_q.size(), budget);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; gulf_tvalid = 1'b0; gal_tready = 1'b1;
    gulf_tdata = '0; gulf_tkeep = '0; gulf_tlast = 1'b0;
    ip = '0; src_prt = '0; dst_prt = '0;
    #1;
    repeat (3) step(1);

    // reset values
    chk("rst_gulf_tready", gulf_tready, 0);
    chk("rst_gal_tvalid", gal_tvalid, 0);
    chk("rst_gal_tlast", gal_tlast, 0);
    chk("rst_gal_tdata", gal_tdata, 0);
    chk("rst_gal_tkeep", gal_tkeep, 0);
    chk("rst_gal_tuser", gal_tuser, 0);
    chk("rst_gal_tdest", gal_tdest, 0);
    chk("rst_drop_count", drop_count, 0);
    step(0);
    step(0);
    chk("ready_after_release", gulf_tready, 1);

    // single-beat hit with 1-cycle latency
    obs_q.delete();
    begin
      beat_t b;
      b = mk(1, 16'd8003, 32'h0A00_0001, 16'h1234);
      b.k = 8'hFF;
      in_q.push_back(b);
    end
    vpct = 100; rmode = 0;
    step(0);
    step(0);
    chk("single_tvalid", gal_tvalid, 1);
    chk("single_tdest", gal_tdest, 3);
    chk("single_tuser", gal_tuser, 48'h1234_0A00_0001);
    chk("single_tlast", gal_tlast, 1);
    chk("single_tkeep", gal_tkeep, 8'hFF);
    drain(20);

    // 4-beat packet; meta inputs change on beats 1-3
    obs_q.delete();
    vpct = 70;
    add_pkt(4, 16'd8001, 32'hC0A8_0105, 16'h4321);
    drain(60);
    chk("pkt4_count", obs_q.size(), 4);
    foreach (obs_q[i]) begin
      chk("pkt4_tdest", obs_q[i].t, 1);
      chk("pkt4_tuser", obs_q[i].u, 48'h4321_C0A8_0105);
    end

    // out-of-range ports, then a passing packet
    obs_q.delete();
    add_pkt(3, 16'd7999, 32'h1, 16'h1);
    add_pkt(3, 16'd8016, 32'h2, 16'h2);
    add_pkt(3, 16'hFFFF, 32'h3, 16'h3);
    add_pkt(3, 16'd8010, 32'hAABB_CCDD, 16'h0077);
    sent.delete();
    for (int i = 9; i < 12; i++) sent.push_back(in_q[i].d);
    drain(80);
    chk("oor_drop_count", drop_count, 3);
    chk("oor_out_count", obs_q.size(), 3);
    foreach (obs_q[i]) begin
      chk("oor_tdest", obs_q[i].t, 10);
      if (i < sent.size()) chk("oor_tdata", obs_q[i].d, sent[i]);
    end

    // back-pressure: gal_tready low for 5 cycles during an 8-beat stream
    obs_q.delete(); sent.delete(); saw_stall = 0;
    vpct = 100;
    add_pkt(8, 16'd8004, 32'h0102_0304, 16'h0506);
    foreach (in_q[i]) sent.push_back(in_q[i].d);
    rmode = 2; bp_lo = cyc + 3; bp_hi = cyc + 8;
    drain(100);
    rmode = 0;
    chk("bp_out_count", obs_q.size(), 8);
    chk("bp_saw_stall", saw_stall, 1);
    foreach (obs_q[i]) if (i < sent.size()) chk("bp_order", obs_q[i].d, sent[i]);

    // back-to-back packets without a gap
    obs_q.delete(); obs_cyc.delete();
    add_pkt(2, 16'd8002, 32'h1111_1111, 16'h2222);
    add_pkt(2, 16'd8015, 32'h3333_3333, 16'h4444);
    drain(40);
    chk("b2b_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      chk("b2b_dest0", obs_q[1].t, 2);
      chk("b2b_dest1", obs_q[2].t, 15);
      chk("b2b_user1", obs_q[2].u, 48'h4444_3333_3333);
      chk("b2b_no_bubble", obs_cyc[2] - obs_cyc[1], 1);
    end

    // reset in the middle of a 4-beat packet
    add_pkt(4, 16'd8005, 32'h5555_5555, 16'h6666);
    for (int i = 1; i < 4; i++) in_q[i].dp = 16'd8007;
    begin
      int n = 0;
      while (in_q.size() > 2 && n < 20) begin step(0); n++; end
    end
    chk("mid_accepted_two", in_q.size(), 2);
    step(1);
    #1;
    chk("mid_rst_tvalid", gal_tvalid, 0);
    chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_ready", gulf_tready, 0);
    obs_q.delete();
    drain(40);
    chk("mid_out_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("mid_tdest", obs_q[0].t, 7);
      chk("mid_tlast", obs_q[1].l, 1);
    end

    // randomized traffic under random back-pressure
    vpct = 70; rmode = 1;
    for (int p = 0; p < 60; p++) begin
      logic [15:0] dp;
      case ($urandom_range(9))
        0:       dp = 16'hFFFF;
        1:       dp = 16'd0;
        default: dp = 16'($urandom_range(7995, 8020));
      endcase
      add_pkt($urandom_range(1, 6), dp, $urandom, 16'($urandom));
    end
    drain(5000);
    rmode = 0;
    step(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
